ahb_subordinate_mem: RTL



---
 rtl/ahb_subordinate_mem_pkg.sv | 45 ++++
 rtl/ahb_sub_lane_decode.sv | 35 +++
 rtl/ahb_subordinate_mem.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_subordinate_mem_pkg.sv
// Shared AHB-Lite types for the subordinate memory model: transfer, burst and
// response encodings, the subordinate FSM state type and HSIZE codes.
package ahb_subordinate_mem_pkg;

    typedef enum logic [1:0] {
        AHB_IDLE   = 2'b00,
        AHB_BUSY   = 2'b01,
        AHB_NONSEQ = 2'b10,
        AHB_SEQ    = 2'b11
    } ahb_transfer_e;

    typedef enum logic [2:0] {
        AHB_SINGLE = 3'b000,
        AHB_INCR   = 3'b001,
        AHB_WRAP4  = 3'b010,
        AHB_INCR4  = 3'b011,
        AHB_WRAP8  = 3'b100,
        AHB_INCR8  = 3'b101,
        AHB_WRAP16 = 3'b110,
        AHB_INCR16 = 3'b111
    } ahb_burst_e;

    typedef enum logic {
        AHB_OKAY  = 1'b0,
        AHB_ERROR = 1'b1
    } ahb_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_sub_state_e;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // NONSEQ and SEQ are the only transfer types that start a data phase.
    function automatic logic ahb_is_active(input logic [1:0] trans);
        return (trans == AHB_NONSEQ) || (trans == AHB_SEQ);
    endfunction

endpackage

// File: rtl/ahb_sub_lane_decode.sv
// Little-endian byte-lane decode for a 32-bit AHB data bus: maps HSIZE and the
// low address bits to the active lane mask and flags misaligned half/word sizes.
module ahb_sub_lane_decode
    import ahb_subordinate_mem_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [1:0] i_addr,
    output logic [3:0] o_lane,
    output logic       o_misalign
);

    // Lane mask and alignment check; sizes above a word decode to no lanes.
    always_comb begin
        o_lane     = '0;
        o_misalign = 1'b0;
        case (i_size)
            HSIZE_BYTE: begin
                o_lane = 4'b0001 << i_addr;
            end
            HSIZE_HALF: begin
                o_lane     = 4'b0011 << i_addr;
                o_misalign = i_addr[0];
            end
            HSIZE_WORD: begin
                o_lane     = 4'b1111;
                o_misalign = |i_addr;
            end
            default: begin
                o_lane     = '0;
                o_misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_subordinate_mem.sv
// AHB-Lite subordinate memory: word-organised RAM with a configurable number of
// wait states per OKAY data phase and a two-cycle ERROR response for
// out-of-range, oversize or misaligned accesses.
// Optional feature macro: AHB_SUB_WSTRB_EN (qualify write lanes with HWSTRB).
module ahb_subordinate_mem
    import ahb_subordinate_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [3:0]            HWSTRB,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    if (WAIT_STATES > 15) begin : g_bad_wait_states
        $error("ahb_subordinate_mem: WAIT_STATES must be in 0..15");
    end
    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("ahb_subordinate_mem: only DATA_WIDTH=32 is supported");
    end

    ahb_sub_state_e        r_state;
    logic                  r_hreadyout;
    ahb_resp_e             r_hresp;
    logic [DATA_WIDTH-1:0] r_hrdata;
    logic [3:0]            r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [2:0]            r_size_q;
    logic                  r_write_q;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_accept;
    logic                  w_can_accept;
    logic                  w_range_err;
    logic                  w_size_err;
    logic                  w_misalign;
    logic                  w_err;
    logic [3:0]            w_acc_lane;
    logic [3:0]            w_lane_q;
    logic                  w_misalign_q;
    logic [3:0]            w_wr_mask;
    logic                  w_wr_en;
    logic [IDX_W-1:0]      w_haddr_idx;
    logic [IDX_W-1:0]      w_idx_q;
    logic [DATA_WIDTH-1:0] w_mem_q;
    logic [DATA_WIDTH-1:0] w_mem_acc;
    logic [DATA_WIDTH-1:0] w_wr_word;
    logic [DATA_WIDTH-1:0] w_fwd_rdata;
    logic                  w_unused;

    // Alignment check on the live address phase.
    ahb_sub_lane_decode u_acc_decode (
        .i_size     (HSIZE),
        .i_addr     (HADDR[1:0]),
        .o_lane     (w_acc_lane),
        .o_misalign (w_misalign)
    );

    // Byte lanes of the captured transfer, used when the write data arrives.
    ahb_sub_lane_decode u_dat_decode (
        .i_size     (r_size_q),
        .i_addr     (r_addr_q[1:0]),
        .o_lane     (w_lane_q),
        .o_misalign (w_misalign_q)
    );

    assign w_accept     = HSEL && HREADY && ahb_is_active(HTRANS);
    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
    assign w_range_err  = {1'b0, HADDR} >= BYTE_LIMIT;
    assign w_size_err   = HSIZE > HSIZE_WORD;
    assign w_err        = w_range_err || w_size_err || w_misalign;

    assign w_haddr_idx  = HADDR[IDX_W+1:2];
    assign w_idx_q      = r_addr_q[IDX_W+1:2];
    assign w_mem_q      = r_mem[w_idx_q];
    assign w_mem_acc    = r_mem[w_haddr_idx];

`ifdef AHB_SUB_WSTRB_EN
    assign w_wr_mask = HWSTRB & w_lane_q;
    assign w_unused  = ^{HBURST, w_acc_lane, w_misalign_q, r_addr_q[ADDR_WIDTH-1:IDX_W+2]};
`else
    assign w_wr_mask = w_lane_q;
    assign w_unused  = ^{HBURST, HWSTRB, w_acc_lane, w_misalign_q, r_addr_q[ADDR_WIDTH-1:IDX_W+2]};
`endif

    assign w_wr_en = (r_state == ST_DATA) && r_write_q && (|w_wr_mask);

    // Merge the enabled HWDATA lanes over the stored word being written.
    always_comb begin
        w_wr_word = w_mem_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_wr_mask[i]) begin
                w_wr_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // A read accepted during a write's final data cycle would sample the
    // array before that write commits, so the merged word is forwarded.
    always_comb begin
        w_fwd_rdata = w_mem_acc;
        if (w_wr_en && (w_idx_q == w_haddr_idx)) begin
            w_fwd_rdata = w_wr_word;
        end
    end

    // Transfer FSM with registered HREADYOUT/HRESP/HRDATA and captured address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= AHB_OKAY;
            r_hrdata    <= '0;
            r_wait_cnt  <= '0;
            r_addr_q    <= '0;
            r_size_q    <= '0;
            r_write_q   <= 1'b0;
        end else if (w_can_accept && w_accept) begin
            r_addr_q   <= HADDR;
            r_size_q   <= HSIZE;
            r_write_q  <= HWRITE;
            r_hrdata   <= '0;
            r_wait_cnt <= '0;
            if (w_err) begin
                r_state     <= ST_ERR1;
                r_hreadyout <= 1'b0;
                r_hresp     <= AHB_ERROR;
            end else if (WAIT_STATES != 0) begin
                r_state     <= ST_WAIT;
                r_hreadyout <= 1'b0;
                r_hresp     <= AHB_OKAY;
                r_wait_cnt  <= WAIT_LOAD;
            end else begin
                r_state     <= ST_DATA;
                r_hreadyout <= 1'b1;
                r_hresp     <= AHB_OKAY;
                if (!HWRITE) begin
                    r_hrdata <= w_fwd_rdata;
                end
            end
        end else begin
            case (r_state)
                ST_WAIT: begin
                    r_hresp <= AHB_OKAY;
                    if (r_wait_cnt == '0) begin
                        r_state     <= ST_DATA;
                        r_hreadyout <= 1'b1;
                        r_hrdata    <= r_write_q ? '0 : w_mem_q;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt - 4'd1;
                        r_hreadyout <= 1'b0;
                        r_hrdata    <= '0;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= AHB_ERROR;
                    r_hrdata    <= '0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= AHB_OKAY;
                    r_hrdata    <= '0;
                end
            endcase
        end
    end

    // Memory array (not reset); commits at the end of a write's final data cycle.
    always_ff @(posedge HCLK) begin
        if (w_wr_en) begin
            r_mem[w_idx_q] <= w_wr_word;
        end
    end

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign HRDATA    = r_hrdata;

endmodule
